la_iosupseq: RTL

Supply-ring segment sequencer for the IO ring. It brings up the ring segments that supply-cut cells separate, one at a time in ascending order: enable, settle, confirm power-good, then release isolation. On request removal it takes them down in reverse order, and it latches a fault on timeout or power-good loss. It sits in the always-on domain next to the pad ring and drives the segment switch and isolation controls.

---
 rtl/la_iosupseq_pkg.sv | 18 +
 rtl/la_iosupseq_dsync.sv | 36 +++
 rtl/la_iosupseq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/la_iosupseq_pkg.sv
// Shared definitions for the IO-ring supply sequencer: state encoding and
// the helper that sizes segment-index fields.
package la_iosupseq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_UNISO  = 3'd2;
  localparam logic [2:0] ST_ON     = 3'd3;
  localparam logic [2:0] ST_ISOL   = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  // A single-segment ring still needs a one-bit index field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_iosupseq_dsync.sv
// Two-flop synchronizer bank bringing the asynchronous per-segment
// power-good signals into the sequencer clock domain.
module la_iosupseq_dsync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  // First stage samples the raw input, second stage filters metastability.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Power-good reads as absent until it has been seen through both stages.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/la_iosupseq.sv
// Supply-ring segment sequencer: powers ring segments up in ascending order
// (enable, settle, confirm power-good, release isolation), powers them down
// in reverse order, and latches a fault on power-good timeout or loss.
module la_iosupseq
  import la_iosupseq_pkg::*;
#(
  parameter string PROP    = "DEFAULT",
  parameter int    RINGW   = 8,
  parameter int    CW      = 8,
  parameter int    TSETTLE = 16,
  parameter int    TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         req,
  input  logic [RINGW-1:0]             pgood,
  output logic [RINGW-1:0]             en,
  output logic [RINGW-1:0]             iso,
  output logic                         ready,
  output logic                         fault,
  output logic [idx_width(RINGW)-1:0]  fault_idx
);

  localparam int IW = idx_width(RINGW);
  localparam logic [IW-1:0] LAST_IDX     = IW'(RINGW - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(TSETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;

  // PROP only selects a cell variant at implementation; this model accepts any value.
  if (PROP == "") begin : g_prop_unset
  end

  logic [RINGW-1:0] pgood_s;
  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RINGW-1:0] en_q, en_d;
  logic [RINGW-1:0] iso_q, iso_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic [IW-1:0]    fault_idx_q, fault_idx_d;
  logic             lost;
  logic [IW-1:0]    lost_idx;
  logic [CW-1:0]    cnt_inc;
  logic [IW-1:0]    idx_inc, idx_dec;
  logic             go_fault;
  logic [IW-1:0]    go_fault_idx;

  la_iosupseq_dsync #(.W(RINGW)) u_pgood_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (pgood),
    .q      (pgood_s)
  );

  // Find the lowest enabled segment whose power-good has dropped.
  always_comb begin
    lost     = 1'b0;
    lost_idx = '0;
    for (int i = RINGW - 1; i >= 0; i--) begin
      if (en_q[i] && !pgood_s[i]) begin
        lost     = 1'b1;
        lost_idx = IW'(i);
      end
    end
  end

  // Sequencer next-state: one segment at a time, abort and fault handling.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    iso_d        = iso_q;
    ready_d      = ready_q;
    fault_d      = fault_q;
    fault_idx_d  = fault_idx_q;
    go_fault     = 1'b0;
    go_fault_idx = '0;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    idx_inc      = idx_q + IW'(1);
    idx_dec      = idx_q - IW'(1);

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          en_d[0] = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!req) begin
          iso_d[idx_q] = 1'b1;
          state_d      = ST_ISOL;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q >= SETTLE_LAST && pgood_s[idx_q]) begin
            iso_d[idx_q] = 1'b0;
            state_d      = ST_UNISO;
          end else if (cnt_q == TIMEOUT_LAST) begin
            go_fault     = 1'b1;
            go_fault_idx = idx_q;
          end
        end
      end
      ST_UNISO: begin
        if (!req) begin
          iso_d[idx_q] = 1'b1;
          state_d      = ST_ISOL;
        end else if (idx_q < LAST_IDX) begin
          en_d[idx_inc] = 1'b1;
          idx_d         = idx_inc;
          cnt_d         = '0;
          state_d       = ST_SETTLE;
        end else begin
          ready_d = 1'b1;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (lost) begin
          go_fault     = 1'b1;
          go_fault_idx = lost_idx;
        end else if (!req) begin
          ready_d      = 1'b0;
          iso_d[idx_q] = 1'b1;
          state_d      = ST_ISOL;
        end
      end
      ST_ISOL: begin
        en_d[idx_q] = 1'b0;
        cnt_d       = '0;
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == SETTLE_LAST) begin
          if (idx_q != '0) begin
            idx_d          = idx_dec;
            iso_d[idx_dec] = 1'b1;
            state_d        = ST_ISOL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (!req) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_fault) begin
      en_d        = '0;
      iso_d       = '1;
      ready_d     = 1'b0;
      fault_d     = 1'b1;
      fault_idx_d = go_fault_idx;
      state_d     = ST_FAULT;
    end
  end

  // State and output registers; reset drops every segment at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      en_q        <= '0;
      iso_q       <= '1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      iso_q       <= iso_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      fault_idx_q <= fault_idx_d;
    end
  end

  assign en        = en_q;
  assign iso       = iso_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign fault_idx = fault_idx_q;

endmodule
